// File: rtl/move_eval_scheduler_pkg.sv
// Shared search types: board, move, score and scheduler state.
// Imported by the move evaluation scheduler and its best tracker.
package move_eval_scheduler_pkg;

  typedef logic [63:0] board_t;

  typedef struct packed {
    logic [5:0] from_sq;
    logic [5:0] to_sq;
    logic [3:0] flags;
  } move_t;

  typedef logic signed [15:0] eval_t;

  localparam eval_t EVAL_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/best_tracker.sv
// Keeps the best-scoring legal move, a found flag and a legal counter.
// Ports: clr_in restarts a node, upd_in presents one legal result.
module best_tracker
  import move_eval_scheduler_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clr_in,
  input  logic             upd_in,
  input  move_t            move_in,
  input  eval_t            eval_in,
  output logic             found_out,
  output move_t            best_move_out,
  output eval_t            best_eval_out,
  output logic [CNT_W-1:0] count_out
);

  logic take;

  // Strict compare: ties keep the earlier move.
  assign take = upd_in &&
                (!found_out || (eval_in > best_eval_out));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      found_out     <= 1'b0;
      best_move_out <= '0;
      best_eval_out <= EVAL_MIN;
      count_out     <= '0;
    end else if (clr_in) begin
      found_out     <= 1'b0;
      best_move_out <= '0;
      best_eval_out <= EVAL_MIN;
      count_out     <= '0;
    end else if (upd_in) begin
      if (count_out != '1)
        count_out <= count_out + 1'b1;
      if (take) begin
        found_out     <= 1'b1;
        best_move_out <= move_in;
        best_eval_out <= eval_in;
      end
    end
  end

endmodule

// File: rtl/move_eval_scheduler.sv
// Issues candidates to the move evaluator and keeps the best legal move.
// Ports: candidate stream in, evaluator link, done/found/best result out.
module move_eval_scheduler
  import move_eval_scheduler_pkg::*;
#(
  parameter int EVAL_LATENCY = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             no_validate_in,
  input  logic             abort_in,
  input  logic             cand_valid_in,
  output logic             cand_ready_out,
  input  board_t           cand_board_in,
  input  move_t            cand_move_in,
  input  logic             cand_last_in,
  output logic             ev_valid_out,
  output board_t           ev_board_out,
  output move_t            ev_move_out,
  output logic             ev_no_validate_out,
  input  logic             ev_valid_in,
  input  move_t            ev_move_in,
  input  eval_t            ev_eval_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             found_out,
  output move_t            best_move_out,
  output eval_t            best_eval_out,
  output logic [CNT_W-1:0] legal_count_out
);

  sched_state_t state, state_nxt;

  logic                    hs;
  logic                    ret;
  logic                    start_go;
  logic                    nv_q;
  logic [EVAL_LATENCY-1:0] infl, infl_nxt;
  logic [CNT_W-1:0]        issued;

  assign cand_ready_out = (state == ISSUE);
  assign hs             = cand_valid_in && cand_ready_out;
  assign start_go       = (state == IDLE) && start_in && !abort_in;

  assign ev_valid_out       = hs;
  assign ev_board_out       = cand_board_in;
  assign ev_move_out        = cand_move_in;
  assign ev_no_validate_out = nv_q;

  assign busy_out = (state != IDLE);
  assign done_out = (state == DONE);

  // Slot tracker: tail bit marks a result due back this cycle,
  // legal or not, so draining never waits on ev_valid_in.
  assign ret      = infl[EVAL_LATENCY-1];
  assign infl_nxt = abort_in ? '0
                  : ((infl << 1) | EVAL_LATENCY'(hs));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_in) state_nxt = ISSUE;
      ISSUE:   if (hs && cand_last_in) state_nxt = DRAIN;
      DRAIN:   if (infl_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_in) state_nxt = IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state  <= IDLE;
      infl   <= '0;
      nv_q   <= 1'b0;
      issued <= '0;
    end else begin
      assert (legal_count_out <= issued);
      state <= state_nxt;
      infl  <= infl_nxt;
      if (start_go) begin
        nv_q   <= no_validate_in;
        issued <= '0;
      end else if (hs && (issued != '1)) begin
        issued <= issued + 1'b1;
      end
    end
  end

  best_tracker #(
    .CNT_W(CNT_W)
  ) u_best (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .clr_in       (start_go),
    .upd_in       (ret && ev_valid_in),
    .move_in      (ev_move_in),
    .eval_in      (ev_eval_in),
    .found_out    (found_out),
    .best_move_out(best_move_out),
    .best_eval_out(best_eval_out),
    .count_out    (legal_count_out)
  );

endmodule

// File: tb/tb_move_eval_scheduler.sv
// Self-checking bench for move_eval_scheduler with an evaluator stand-in.
// Directed node scenarios plus randomized nodes against a queue model.
module tb_move_eval_scheduler;
  import move_eval_scheduler_pkg::*;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b1;
  logic             start_in = 1'b0;
  logic             no_validate_in = 1'b0;
  logic             abort_in = 1'b0;
  logic             cand_valid_in = 1'b0;
  logic             cand_ready_out;
  board_t           cand_board_in = '0;
  move_t            cand_move_in = '0;
  logic             cand_last_in = 1'b0;
  logic             ev_valid_out;
  board_t           ev_board_out;
  move_t            ev_move_out;
  logic             ev_no_validate_out;
  logic             ev_valid_in;
  move_t            ev_move_in;
  eval_t            ev_eval_in;
  logic             busy_out;
  logic             done_out;
  logic             found_out;
  move_t            best_move_out;
  eval_t            best_eval_out;
  logic [CNT_W-1:0] legal_count_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  move_eval_scheduler #(
    .EVAL_LATENCY(1),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .start_in          (start_in),
    .no_validate_in    (no_validate_in),
    .abort_in          (abort_in),
    .cand_valid_in     (cand_valid_in),
    .cand_ready_out    (cand_ready_out),
    .cand_board_in     (cand_board_in),
    .cand_move_in      (cand_move_in),
    .cand_last_in      (cand_last_in),
    .ev_valid_out      (ev_valid_out),
    .ev_board_out      (ev_board_out),
    .ev_move_out       (ev_move_out),
    .ev_no_validate_out(ev_no_validate_out),
    .ev_valid_in       (ev_valid_in),
    .ev_move_in        (ev_move_in),
    .ev_eval_in        (ev_eval_in),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .found_out         (found_out),
    .best_move_out     (best_move_out),
    .best_eval_out     (best_eval_out),
    .legal_count_out   (legal_count_out)
  );

  // Evaluator stand-in: board bit 63 = legal, bits 15:0 = score.
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ev_valid_in <= 1'b0;
      ev_move_in  <= '0;
      ev_eval_in  <= '0;
    end else begin
      ev_valid_in <= ev_valid_out &&
                     (ev_board_out[63] || ev_no_validate_out);
      ev_move_in  <= ev_move_out;
      ev_eval_in  <= eval_t'(ev_board_out[15:0]);
    end
  end

  task automatic chk(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit    legal;
    eval_t ev;
    move_t mv;
  } cand_s;

  cand_s  m_q[$];
  bit     m_busy = 0;
  bit     m_acc = 0;
  bit     m_nv = 0;
  bit     m_res_ok = 0;
  bit     m_fresh = 0;
  longint cyc = 0;
  longint m_done = -1;

  // Best = first legal candidate holding the maximum score.
  task automatic model_result(output bit f, output move_t bm,
                              output eval_t be, output int cnt);
    eval_t mx;
    f = 0; bm = '0; be = EVAL_MIN; cnt = 0; mx = EVAL_MIN;
    foreach (m_q[i])
      if (m_q[i].legal) begin
        if (cnt == 0 || m_q[i].ev > mx) mx = m_q[i].ev;
        cnt++;
      end
    if (cnt > 0) begin
      f = 1;
      be = mx;
      for (int i = 0; i < m_q.size(); i++)
        if (m_q[i].legal && m_q[i].ev == mx) begin
          bm = m_q[i].mv;
          break;
        end
    end
    if (cnt > 255) cnt = 255;
  endtask

  always @(negedge clk_in) begin
    bit    ef;
    move_t em;
    eval_t ee;
    int    ec;
    if (!rst_n_in) begin
      chk("rst_ready", cand_ready_out, 0);
      chk("rst_ev_valid", ev_valid_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_done", done_out, 0);
      chk("rst_nv", ev_no_validate_out, 0);
      chk("rst_found", found_out, 0);
      chk("rst_move", best_move_out, 0);
      chk("rst_eval", best_eval_out, -32768);
      chk("rst_count", legal_count_out, 0);
    end else begin
      chk("ready", cand_ready_out, m_acc);
      chk("ev_valid", ev_valid_out, cand_valid_in && m_acc);
      chk("ev_board", ev_board_out, cand_board_in);
      chk("ev_move", ev_move_out, cand_move_in);
      chk("busy", busy_out, m_busy);
      chk("done", done_out, cyc == m_done);
      if (m_busy) chk("ev_nv", ev_no_validate_out, m_nv);
      if (m_fresh) begin
        chk("start_found", found_out, 0);
        chk("start_eval", best_eval_out, -32768);
        chk("start_count", legal_count_out, 0);
      end
      if (cyc == m_done || m_res_ok) begin
        model_result(ef, em, ee, ec);
        chk("res_found", found_out, ef);
        chk("res_move", best_move_out, em);
        chk("res_eval", best_eval_out, ee);
        chk("res_count", legal_count_out, ec);
      end
    end
    m_fresh = 0;
    if (!rst_n_in) begin
      m_busy = 0; m_acc = 0; m_nv = 0;
      m_done = -1; m_q.delete(); m_res_ok = 1;
    end else if (abort_in) begin
      m_busy = 0; m_acc = 0; m_done = -1; m_res_ok = 0;
    end else if (m_busy && cyc == m_done) begin
      m_busy = 0; m_res_ok = 1;
    end else if (!m_busy && start_in) begin
      m_busy = 1; m_acc = 1; m_nv = no_validate_in;
      m_q.delete(); m_fresh = 1; m_res_ok = 0;
    end else if (m_acc && cand_valid_in) begin
      m_q.push_back('{cand_board_in[63] || m_nv,
                      eval_t'(cand_board_in[15:0]),
                      cand_move_in});
      if (cand_last_in) begin
        m_acc = 0;
        m_done = cyc + 2;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic board_t brd(input bit lg, input eval_t e);
    board_t b;
    b = {$urandom, $urandom};
    b[63] = lg;
    b[15:0] = e;
    return b;
  endfunction

  task automatic begin_node(input bit nv);
    start_in = 1'b1;
    no_validate_in = nv;
    step();
    start_in = 1'b0;
    no_validate_in = 1'b0;
  endtask

  task automatic issue(input board_t b, input move_t m,
                       input bit last);
    cand_valid_in = 1'b1;
    cand_board_in = b;
    cand_move_in = m;
    cand_last_in = last;
    step();
    cand_valid_in = 1'b0;
    cand_last_in = 1'b0;
  endtask

  // Called in the cycle after the last issue; lat counts from it.
  task automatic wait_done(input int exp_lat);
    int lat;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_in);
      if (done_out) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", lat, exp_lat);
  endtask

  task automatic rand_node();
    int    nc, ab, gaps;
    bit    nv, lg;
    eval_t ev;
    move_t mv;
    nc = $urandom_range(1, 8);
    nv = ($urandom_range(0, 7) == 0);
    ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nc - 1) : -1;
    begin_node(nv);
    for (int i = 0; i < nc; i++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        start_in = ($urandom_range(0, 7) == 0);
        step();
        start_in = 1'b0;
      end
      case ($urandom_range(0, 3))
        0: ev = eval_t'(int'($urandom_range(0, 6)) - 3);
        1: ev = EVAL_MIN;
        2: ev = 16'sh7fff;
        default: ev = eval_t'($urandom_range(0, 65535));
      endcase
      lg = ($urandom_range(0, 2) != 0);
      mv = 16'($urandom_range(0, 65535));
      if (i == ab) begin
        abort_in = 1'b1;
        issue(brd(lg, ev), mv, 1'b0);
        abort_in = 1'b0;
        break;
      end
      issue(brd(lg, ev), mv, i == nc - 1);
    end
    step();
    step();
  endtask

  localparam move_t MA = 16'h0A01;
  localparam move_t MB = 16'h0B02;
  localparam move_t MC = 16'h0C03;
  localparam move_t MD = 16'h0D04;

  initial begin
    bit nodone;
    #1 rst_n_in = 1'b0;
    repeat (3) step();
    rst_n_in = 1'b1;
    step();

    // 100, 250, 250: tie keeps B.
    begin_node(0);
    issue(brd(1, 100), MA, 0);
    issue(brd(1, 250), MB, 0);
    issue(brd(1, 250), MC, 1);
    wait_done(2);
    chk("s1_move", best_move_out, MB);
    chk("s1_eval", best_eval_out, 250);
    chk("s1_found", found_out, 1);
    chk("s1_count", legal_count_out, 3);
    step();

    // Illegal 2nd/4th carry high scores that must be ignored.
    begin_node(0);
    issue(brd(1, -40), MA, 0);
    issue(brd(0, 500), MB, 0);
    issue(brd(1, -10), MC, 0);
    issue(brd(0, 900), MD, 1);
    wait_done(2);
    chk("s2_move", best_move_out, MC);
    chk("s2_eval", best_eval_out, -10);
    chk("s2_count", legal_count_out, 2);
    step();

    // Single illegal candidate.
    begin_node(0);
    issue(brd(0, 77), MA, 1);
    wait_done(2);
    chk("s3_found", found_out, 0);
    chk("s3_eval", best_eval_out, -32768);
    chk("s3_move", best_move_out, 0);
    step();

    // Gapped stream 1,0,0,1,1.
    begin_node(0);
    issue(brd(1, 5), MA, 0);
    step();
    step();
    issue(brd(1, 9), MB, 0);
    issue(brd(1, 3), MC, 1);
    wait_done(2);
    chk("s4_move", best_move_out, MB);
    chk("s4_count", legal_count_out, 3);
    step();

    // Abort with a handshake on the 3rd issue; then clean node.
    begin_node(0);
    issue(brd(1, 300), MA, 0);
    issue(brd(1, 400), MB, 0);
    abort_in = 1'b1;
    issue(brd(1, 500), MC, 0);
    abort_in = 1'b0;
    @(negedge clk_in);
    chk("s5_idle", busy_out, 0);
    nodone = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      if (done_out) nodone = 0;
    end
    chk("s5_no_done", nodone, 1);
    step();
    begin_node(0);
    issue(brd(1, 7), MD, 1);
    wait_done(2);
    chk("s5_eval", best_eval_out, 7);
    chk("s5_count", legal_count_out, 1);
    chk("s5_move", best_move_out, MD);
    step();

    // No-validate node: illegal boards count as legal.
    begin_node(1);
    issue(brd(0, -2), MA, 0);
    issue(brd(0, -1), MB, 1);
    wait_done(2);
    chk("nv_move", best_move_out, MB);
    chk("nv_count", legal_count_out, 2);
    step();

    // Asynchronous reset mid-DRAIN.
    begin_node(0);
    issue(brd(1, 50), MA, 0);
    issue(brd(1, 60), MB, 1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("ar_busy", busy_out, 0);
    chk("ar_found", found_out, 0);
    chk("ar_eval", best_eval_out, -32768);
    chk("ar_move", best_move_out, 0);
    chk("ar_count", legal_count_out, 0);
    step();
    step();
    rst_n_in = 1'b1;
    step();
    begin_node(0);
    issue(brd(1, -5), MC, 1);
    wait_done(2);
    chk("ar_post_eval", best_eval_out, -5);
    chk("ar_post_count", legal_count_out, 1);
    step();

    for (int n = 0; n < 60; n++) rand_node();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/move_eval_scheduler.md
Name: move_eval_scheduler

Overview:
- Sequences the single-cycle-latency move evaluator for one search node.
- Accepts a stream of (resulting board, move) candidates, issues one candidate per cycle to the evaluator, and tracks in-flight slots independently of the evaluator's legality-gated valid.
- Keeps the best-scoring legal move and reports best move, best score and a found flag when the stream ends.
- Sits between the move generator (upstream) and the search controller (downstream).

Parameters:
- EVAL_LATENCY, 1, clock cycles from evaluator valid_in to valid_out; the in-flight tracker depth.
- CNT_W, 8, width of issued/legal counters; maximum candidates per node is 2^CNT_W - 1.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  pulse: begin a new node; ignored unless state is IDLE
- no_validate_in  input  1  sampled on start; drives evaluator no_validate for the whole node
- abort_in  input  1  drop current node, return to IDLE, no done pulse
- cand_valid_in  input  1  candidate present
- cand_ready_out  output  1  scheduler accepts candidate this cycle
- cand_board_in  input  $bits(board_t)  board after move executed
- cand_move_in  input  $bits(move_t)  move producing that board
- cand_last_in  input  1  this candidate is the final one of the node
- ev_valid_out  output  1  to evaluator valid_in
- ev_board_out  output  $bits(board_t)  to evaluator board_in
- ev_move_out  output  $bits(move_t)  to evaluator last_move_in
- ev_no_validate_out  output  1  to evaluator no_validate
- ev_valid_in  input  1  evaluator valid_out (legal and valid)
- ev_move_in  input  $bits(move_t)  evaluator move_out
- ev_eval_in  input  16  evaluator eval_out, signed eval_t
- busy_out  output  1  state is not IDLE
- done_out  output  1  one-cycle pulse: result valid
- found_out  output  1  at least one legal candidate; held until next start
- best_move_out  output  $bits(move_t)  best legal move; held
- best_eval_out  output  16  signed best score; held
- legal_count_out  output  CNT_W  number of legal candidates seen in this node

Behaviour:
- Reset (asynchronous, rst_n_in low): state IDLE. All outputs 0, except best_eval_out = -32768. In-flight shift register and counters cleared.
- States:
  - IDLE
  - ISSUE: accepting candidates.
  - DRAIN: waiting for in-flight results.
  - DONE: one cycle, asserts done_out.
- IDLE -> ISSUE on start_in. The same edge does all of the following:
  - latches no_validate_in
  - sets best_eval to -32768, found to 0, legal_count to 0
  - clears issued_count
- cand_ready_out = (state == ISSUE). Combinational from state only; no dependency on cand_valid_in.
- Handshake and issue:
  - A handshake occurs when cand_valid_in and cand_ready_out are both high.
  - ev_valid_out equals the handshake, combinationally.
  - ev_board_out and ev_move_out are pass-through of the candidate inputs. The evaluator registers them internally; the scheduler adds no latency.
- In-flight tracker: EVAL_LATENCY-deep shift register fed with the handshake bit. Its tail bit "ret" marks a returning slot, whether the candidate was legal or not.
- On ret with ev_valid_in = 1:
  - legal_count increments, saturating at all-ones.
  - If found == 0 or ev_eval_in > best_eval (signed strict compare), update best_move with ev_move_in and best_eval with ev_eval_in, and set found.
  - Ties keep the earlier candidate.
- On ret with ev_valid_in = 0: the candidate was illegal and is discarded. An ev_valid_in with ret = 0 is a protocol error and is ignored.
- ISSUE -> DRAIN on a handshake with cand_last_in = 1. The candidate stream must not present cand_last_in without valid.
- DRAIN -> DONE in the cycle after the tracker becomes all-zero, which is exactly EVAL_LATENCY cycles after the last issue.
- DONE -> IDLE unconditionally.
- done_out is high for exactly one cycle, in DONE.
- busy_out is high in ISSUE, DRAIN and DONE.
- Latency: with EVAL_LATENCY = 1, the last issue at cycle t gives its result at t+1 and done_out at t+2.
- Zero legal candidates: done_out still pulses, with found_out = 0, best_move_out = 0, best_eval_out = -32768.
- Candidate count overflow:
  - A handshake that would take issued_count past its maximum is still accepted.
  - issued_count saturates; nothing else changes.
  - Software guarantees candidates per node stay within the maximum.
- abort_in:
  - Highest priority in any state. It forces IDLE and clears the tracker next cycle; no done pulse.
  - Best/found outputs keep their partial values, which are not meaningful.
  - An abort together with a handshake: the handshake still drives ev_valid_out that cycle, and the result is dropped.
- start_in outside IDLE is ignored. start_in together with abort_in: abort wins, start is ignored.
- Reset asserted mid-node behaves as abort plus the reset values above.

Decomposition:
- board_t, move_t, eval_t, EVAL_MIN (-32768) come from the shared types package. Add there: sched_state_t enum {IDLE, ISSUE, DRAIN, DONE}.
- One sub-module: best_tracker (signed compare and update, found flag, legal counter). It is reusable by the search controller's root-move selection.

Test Plan:
- Reset, then start. Issue 3 candidates returning legal with evals 100, 250, 250 (moves A, B, C). Required: done 2 cycles after the last issue, best = B/250, found = 1, legal_count = 3.
- 4 candidates with the 2nd and 4th returned ev_valid_in = 0, legal evals -40 and -10. Required: best = -10 move, legal_count = 2.
- Start then a single candidate with last that is illegal. Required: done pulse, found = 0, best_eval = -32768, best_move = 0.
- Candidates with cand_valid_in gapped (valid 1,0,0,1,1 with last on the fifth cycle). Required: ev_valid_out mirrors the handshakes exactly, and done arrives 2 cycles after the final handshake.
- abort_in on the cycle after the 2nd issue of 5. Required: IDLE next cycle, no done pulse. A following start with one legal candidate of eval 7 gives best = 7 and legal_count = 1 (no carry-over).
- rst_n_in pulsed low asynchronously mid-DRAIN, between clock edges. Required: outputs at reset values immediately, and start_in is honoured after release.
